// File: rtl/serial_pkg.sv
// Shared types and widths for the serializer blocks.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package serial_pkg;

  // Serializer control states; IDLE is the reset encoding.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    GAP   = 2'd2
  } state_e;

  localparam int WORD_CNT_W = 8;  // completed-word counter width
  localparam int GAP_CNT_W  = 4;  // inter-word gap counter width (0..15)

endpackage

// File: rtl/piso_bit_counter.sv
// Bit-position counter for the serializer: clears on load, advances per transferred bit.
// Latency: index updates on the edge after clear/advance; last is combinational from index.
// Backpressure: none of its own; advance is only asserted on an accepted bit.
//
// Ports:
//   Clock, Reset    : clock, async active-low reset
//   clear           : force index to 0 (has priority over advance)
//   advance         : step to the next bit; wraps to 0 after the last bit
//   index           : current bit position within the word
//   last            : index is the final bit position (WIDTH-1)
module piso_bit_counter
  import serial_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int IDX_W = $clog2(WIDTH)
) (
  input  logic             Clock,
  input  logic             Reset,
  input  logic             clear,
  input  logic             advance,
  output logic [IDX_W-1:0] index,
  output logic             last
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WIDTH - 1);

  logic [IDX_W-1:0] index_q, index_d;

  always_comb begin
    index_d = index_q;
    if (clear) begin
      index_d = '0;
    end else if (advance) begin
      // Wrap explicitly so non-power-of-two widths never leave the valid range.
      index_d = (index_q == LAST_IDX) ? '0 : index_q + 1'b1;
    end
  end

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      index_q <= '0;
    end else begin
      index_q <= index_d;
    end
  end

  assign index = index_q;
  assign last  = (index_q == LAST_IDX);

endmodule

// File: rtl/piso_serializer.sv
// Parallel-in/serial-out stage: loads a WIDTH-bit word on valid/ready and shifts it out one bit per transfer.
// Latency: first bit on Serial_Out the cycle after accept; WIDTH transfers per word, then GAP_CYCLES idle cycles.
// Backpressure: Serial_Ready low holds the current bit and markers; Load_Ready drops while a word is in flight.
//
// Ports:
//   Clock, Reset      : clock, async active-low reset (all outputs 0 while in reset)
//   Data_In           : parallel word, sampled only on accept
//   Load_Valid/Ready  : word load handshake; Ready also asserts on a back-to-back last bit when GAP_CYCLES==0
//   Serial_Ready      : downstream accepts the current bit
//   Serial_Out/Valid  : current serial bit and its qualifier
//   Frame_Start/End   : first / last bit of a word
//   Busy              : in SHIFT or GAP
//   Word_Count        : completed words, modulo 256
module piso_serializer
  import serial_pkg::*;
#(
  parameter int WIDTH      = 4,
  parameter int MSB_FIRST  = 1,
  parameter int GAP_CYCLES = 0
) (
  input  logic                  Clock,
  input  logic                  Reset,
  input  logic [WIDTH-1:0]      Data_In,
  input  logic                  Load_Valid,
  output logic                  Load_Ready,
  input  logic                  Serial_Ready,
  output logic                  Serial_Out,
  output logic                  Serial_Valid,
  output logic                  Frame_Start,
  output logic                  Frame_End,
  output logic                  Busy,
  output logic [WORD_CNT_W-1:0] Word_Count
);

  localparam int IDX_W  = $clog2(WIDTH);
  localparam bit NO_GAP = (GAP_CYCLES == 0);
  localparam logic [GAP_CNT_W-1:0] GAP_INIT =
    (GAP_CYCLES > 0) ? GAP_CNT_W'(GAP_CYCLES - 1) : '0;

  state_e                  state_q, state_d;
  logic [WIDTH-1:0]        sreg_q, sreg_d;
  logic [GAP_CNT_W-1:0]    gap_q, gap_d;
  logic [WORD_CNT_W-1:0]   wcnt_q, wcnt_d;
  // Holds Load_Ready low until the first edge after reset so IDLE does not
  // advertise readiness while Reset is still asserted.
  logic                    rdy_en_q, rdy_en_d;

  logic [IDX_W-1:0]        bit_idx;
  logic                    bit_last;
  logic                    in_shift;
  logic                    xfer;
  logic                    last_xfer;
  logic                    load_ready;
  logic                    accept;

  assign in_shift  = (state_q == SHIFT);
  assign xfer      = in_shift & Serial_Ready;
  assign last_xfer = xfer & bit_last;

  // Serial_Ready -> Load_Ready is combinational so a new word can follow the
  // last bit with no bubble.
  assign load_ready = rdy_en_q & ((state_q == IDLE) | (last_xfer & NO_GAP));
  assign accept     = Load_Valid & load_ready;

  piso_bit_counter #(
    .WIDTH (WIDTH),
    .IDX_W (IDX_W)
  ) u_bit_counter (
    .Clock   (Clock),
    .Reset   (Reset),
    .clear   (accept),
    .advance (xfer),
    .index   (bit_idx),
    .last    (bit_last)
  );

  always_comb begin
    state_d  = state_q;
    sreg_d   = sreg_q;
    gap_d    = gap_q;
    wcnt_d   = wcnt_q;
    rdy_en_d = 1'b1;

    if (accept) begin
      // Also covers the back-to-back case where the last bit leaves this cycle.
      sreg_d  = Data_In;
      state_d = SHIFT;
    end else if (xfer) begin
      // Zero fill means the register is empty (Serial_Out=0) once the word is out.
      if (MSB_FIRST != 0) begin
        sreg_d = sreg_q << 1;
      end else begin
        sreg_d = sreg_q >> 1;
      end
      if (bit_last) begin
        if (NO_GAP) begin
          state_d = IDLE;
        end else begin
          state_d = GAP;
          gap_d   = GAP_INIT;
        end
      end
    end else if (state_q == GAP) begin
      if (gap_q == '0) begin
        state_d = IDLE;
      end else begin
        gap_d = gap_q - 1'b1;
      end
    end

    if (last_xfer) begin
      wcnt_d = wcnt_q + 1'b1;
    end
  end

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      state_q  <= IDLE;
      sreg_q   <= '0;
      gap_q    <= '0;
      wcnt_q   <= '0;
      rdy_en_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      sreg_q   <= sreg_d;
      gap_q    <= gap_d;
      wcnt_q   <= wcnt_d;
      rdy_en_q <= rdy_en_d;
    end
  end

  assign Load_Ready   = load_ready;
  assign Serial_Out   = (MSB_FIRST != 0) ? sreg_q[WIDTH-1] : sreg_q[0];
  assign Serial_Valid = in_shift;
  assign Frame_Start  = in_shift & (bit_idx == '0);
  assign Frame_End    = in_shift & bit_last;
  assign Busy         = (state_q != IDLE);
  assign Word_Count   = wcnt_q;

endmodule

// File: doc/piso_serializer.md
# piso_serializer

Parallel-in/serial-out stage that accepts a WIDTH-bit word from the upstream parallel register and shifts it out one bit per transfer. It sits between the PIPO capture register and the serial link driver. A valid/ready handshake controls loading, and downstream back-pressure controls each bit. Frame markers and a word counter support link framing and debug.

## Interface
- WIDTH, 4: word width in bits; minimum 2.
- MSB_FIRST, 1: 1 = bit WIDTH-1 is sent first; 0 = bit 0 is sent first.
- GAP_CYCLES, 0: idle cycles forced between words; range 0–15.
- Clock  input  1  clock; all state updates on the rising edge.
- Reset  input  1  asynchronous, active-low reset.
- Data_In  input  WIDTH  parallel word from the upstream register.
- Load_Valid  input  1  Data_In holds a word to send.
- Load_Ready  output  1  serializer can accept a word this cycle.
- Serial_Ready  input  1  downstream accepts the current bit.
- Serial_Out  output  1  current serial bit.
- Serial_Valid  output  1  Serial_Out carries a valid bit.
- Frame_Start  output  1  high with the first bit of a word.
- Frame_End  output  1  high with the last bit of a word.
- Busy  output  1  high in SHIFT or GAP.
- Word_Count  output  8  number of completed words; wraps modulo 256.

## Operation
- Reset value of every output is 0, including Load_Ready. After Reset deasserts, the block enters IDLE.
- States:
  - IDLE: Load_Ready=1, Serial_Valid=0, Serial_Out=0.
  - SHIFT: Serial_Valid=1.
  - GAP: Serial_Valid=0, Load_Ready=0.
- Load (accept): Load_Valid & Load_Ready at a rising edge. On accept, Data_In is copied into the shift register, the bit index clears to 0, and the state goes to SHIFT.
- Bit transfer: Serial_Valid & Serial_Ready at a rising edge.
  - On transfer, the shift register shifts by one (left when MSB_FIRST=1, right otherwise) and the bit index increments.
  - Without a transfer, Serial_Out and all markers hold.
- Serial_Out always equals the head bit of the shift register: bit WIDTH-1 when MSB_FIRST=1, bit 0 otherwise.
- Frame_Start = SHIFT & index==0. Frame_End = SHIFT & index==WIDTH-1.
- Last-bit transfer (Frame_End & Serial_Ready):
  - Word_Count increments; 255 wraps to 0.
  - If GAP_CYCLES>0: go to GAP, load the gap counter with GAP_CYCLES-1, and count down. At 0, return to IDLE.
  - If GAP_CYCLES=0 and Load_Valid is high in the same cycle: back-to-back accept. Load_Ready is high that cycle, the new word loads, and the state stays in SHIFT.
  - If GAP_CYCLES=0 and Load_Valid is low: go to IDLE.
- Load_Ready = IDLE | (SHIFT & Frame_End & Serial_Ready & GAP_CYCLES==0). The path from Serial_Ready to Load_Ready is combinational; this is accepted by design.
- Data_In changes while in SHIFT or GAP are ignored.
- Reset asserted mid-word:
  - The partial word is discarded and Word_Count clears.
  - Outputs drop to 0 asynchronously.
  - No Frame_End is emitted for the discarded word.

## Timing
- Accept at edge N: the first bit is valid on Serial_Out in the cycle after edge N.
- With Serial_Ready held high, a word occupies exactly WIDTH cycles of Serial_Valid.
- Steady-state throughput:
  - GAP_CYCLES=0: one word per WIDTH cycles, with no bubble.
  - GAP_CYCLES>0: one word per WIDTH+GAP_CYCLES+1 cycles. This comprises WIDTH cycles of SHIFT, GAP_CYCLES cycles of GAP, and one IDLE accept cycle.
- Serial_Ready low stretches the current bit indefinitely. No bit is lost or duplicated.
- Word_Count updates on the edge of the last-bit transfer and is visible in the following cycle.

## Structure
- Shared package `serial_pkg`:
  - State enum (IDLE, SHIFT, GAP), 2-bit encoding.
  - Constants WORD_CNT_W=8 and GAP_CNT_W=4.
- Sub-module `piso_bit_counter`:
  - Inputs: clear and advance.
  - Outputs: index and last flag, with async active-low reset.
  - Instantiated once and sized by $clog2(WIDTH).
- The top module holds the FSM, shift register, gap counter and word counter.

## Test plan
- Reset then single word, default parameters: Data_In=4'b1011, Load_Valid pulsed one cycle, Serial_Ready=1. Required: Serial_Out 1,0,1,1 over 4 cycles; Frame_Start in cycle 1; Frame_End in cycle 4; Word_Count=1.
- MSB_FIRST=0, Data_In=4'b1011. Required: Serial_Out 1,1,0,1.
- Back-pressure: Serial_Ready low for 3 cycles on the second bit of 4'b0110. Required: Serial_Out holds 1 with Serial_Valid=1 for the stall; full sequence 0,1,1,0; Frame_End fires once.
- Back-to-back, GAP_CYCLES=0: words 4'hA then 4'h5 with Load_Valid held. Required: 8 contiguous Serial_Valid cycles carrying 1,0,1,0,0,1,0,1; Load_Ready high only in IDLE and on cycle 4; Word_Count=2.
- GAP_CYCLES=2, two words queued. Required: Serial_Valid pattern 1111 0 0 0 1111 (two GAP cycles plus one IDLE accept cycle); Busy high through GAP.
- Reset asserted after the 2nd bit: outputs go to 0 immediately. After Reset releases, Word_Count=0 and Load_Ready=1 on the first edge. A new word 4'hF serializes as 1,1,1,1.
